ring_osc_freq_meter: RTL and testbench
======================================

Name: ring_osc_freq_meter

Overview:
- Downstream consumer of the ring oscillator. It enables the oscillator and synchronizes its asynchronous `clk_out` into the system clock domain.
- It counts oscillator rising edges over a fixed gate window of system-clock cycles and reports the count, which is proportional to oscillator frequency.
- Used to characterise inverter delay / stage count against a known reference clock.

Parameters:
- CNT_W, 16, width of the edge-count result.
- SETTLE_CYCLES, 8, clk cycles the oscillator runs after enable before counting starts (>=1).
- GATE_CYCLES, 1000, clk cycles of the counting window (>=1).
- SYNC_STAGES, 2, synchronizer flop depth on osc_in (>=2).

Ports:
- clk  input  1  system/reference clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a measurement; sampled only in IDLE.
- osc_in  input  1  oscillator output (asynchronous to clk); connects to the oscillator's clk_out.
- osc_en  output  1  oscillator enable; connects to the oscillator's en.
- busy  output  1  high in SETTLE, MEASURE, DONE.
- done  output  1  one-cycle pulse when count is updated.
- count  output  CNT_W  rising edges counted in the last completed window.
- overflow  output  1  the last window saturated count.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State becomes IDLE.
  - osc_en, busy, done, overflow, count are 0; synchronizer, edge-detect and internal counters are 0.
  - Reset mid-operation aborts with no done pulse; osc_en drops on the next edge.
- Synchronizer and edge detect:
  - osc_in passes through SYNC_STAGES flops plus one delay flop.
  - rise = sync_out & ~delayed.
  - Legal only when the osc frequency is < clk/2; faster inputs alias and are not flagged.
- FSM states: IDLE, SETTLE, MEASURE, DONE. Timing is relative to cycle t, the edge where start=1 is sampled in IDLE.
  - IDLE: osc_en=0, busy=0. start=1 -> SETTLE; timer loaded SETTLE_CYCLES-1.
  - SETTLE: occupies cycles t+1 .. t+SETTLE_CYCLES. osc_en=1, busy=1. Timer decrements; at 0 -> MEASURE, with edge counter and overflow flag cleared and timer loaded GATE_CYCLES-1.
  - MEASURE: occupies exactly GATE_CYCLES cycles. osc_en=1. Each cycle with rise=1 increments the edge counter. The counter saturates at 2^CNT_W-1 and sets the internal overflow flag. Timer 0 -> DONE.
  - DONE: one cycle at t+SETTLE_CYCLES+GATE_CYCLES+1. done=1; count and overflow outputs show the new result in this same cycle. osc_en=0, busy=1. Next state is IDLE unconditionally.
- start is ignored in SETTLE, MEASURE and DONE; held-high start re-triggers only once back in IDLE.
- count/overflow outputs hold their value until the next DONE or reset; they are not cleared at start.
- Timer width is $clog2(max(SETTLE_CYCLES, GATE_CYCLES)+1).
- A rise whose synchronized edge lands in the last SETTLE cycle is not counted. A rise landing in the last MEASURE cycle is counted.
- Synchronizer flops are never reset by osc_en; stale edges from a stopping oscillator during DONE/IDLE are ignored because counting happens only in MEASURE.

Decomposition:
- Package ring_osc_pkg:
  - state enum (IDLE, SETTLE, MEASURE, DONE);
  - default width constants;
  - a function returning the saturation value for a given CNT_W.
- One sub-module: sync_edge_detect (parameter SYNC_STAGES; ports clk, rst, async_in, sync_out, rise). Reused wherever oscillator outputs cross into clk.

Test Plan:
- Reset with osc_in toggling -> osc_en=0, busy=0, done=0, count=0, overflow=0 every cycle while rst=1 and after release with no start.
- SETTLE_CYCLES=8, GATE_CYCLES=100, osc_in = clk/4 square wave phase-locked to clk, start pulsed at cycle 0:
  - osc_en=1 on cycles 1..108;
  - done=1 only at cycle 109 with count=25, overflow=0;
  - busy=0 at cycle 110.
- Same setup with osc_in held at 0 -> done at cycle 109, count=0, overflow=0.
- CNT_W=4, GATE_CYCLES=100, osc_in = clk/2 (-> ~50 edges) -> count=15, overflow=1 at done.
- start held high from cycle 0 -> measurements complete at cycles 109 and 219 (next start sampled at 110); pulses of start during busy are ignored; count holds the first result between the two done pulses.
- rst=1 at cycle 50 (inside MEASURE) -> cycle 51: osc_en=0, busy=0, count=0; no done pulse; a new start afterwards produces a normal measurement.

Source files
------------

// File: rtl/ring_osc_pkg.sv
// rtl/ring_osc_pkg.sv - shared types and constants for the ring oscillator frequency meter
// Contents: measurement FSM state type, default parameter values,
//           saturation-value helper for the edge counter.
package ring_osc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEF_CNT_W         = 16;
  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_GATE_CYCLES   = 1000;
  localparam int DEF_SYNC_STAGES   = 2;

  // Largest value representable in a w-bit counter (w up to 63).
  function automatic logic [63:0] sat_value(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer with rising-edge detect
// Ports:
//   clk      in   sampling clock
//   rst      in   synchronous active-high reset
//   async_in in   signal asynchronous to clk
//   sync_out out  async_in after SYNC_STAGES flops
//   rise     out  one-cycle pulse when sync_out goes 0 -> 1
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delayed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      delayed_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], async_in};
      delayed_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~delayed_q;

endmodule

// File: rtl/ring_osc_freq_meter.sv
// rtl/ring_osc_freq_meter.sv - gated edge counter measuring ring oscillator frequency
// Ports:
//   clk      in   reference clock, all logic on rising edge
//   rst      in   synchronous active-high reset
//   start    in   measurement request, sampled only in IDLE
//   osc_in   in   oscillator output, asynchronous to clk
//   osc_en   out  oscillator enable (SETTLE and MEASURE)
//   busy     out  high in SETTLE, MEASURE, DONE
//   done     out  one-cycle pulse when count/overflow are updated
//   count    out  rising edges counted in the last completed window
//   overflow out  last window saturated the counter
module ring_osc_freq_meter
  import ring_osc_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             osc_in,
  output logic             osc_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(sat_value(CNT_W));

  state_t             state, state_next;
  logic [TMR_W-1:0]   timer;
  logic [CNT_W-1:0]   edge_cnt;
  logic               ovf_flag;
  logic [CNT_W-1:0]   cnt_inc;
  logic               ovf_inc;
  logic               rise;
  logic               timer_zero;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (osc_in),
    .sync_out (),
    .rise     (rise)
  );

  assign timer_zero = (timer == '0);

  // Saturating increment; overflow marks a window where an edge was lost.
  always_comb begin
    cnt_inc = edge_cnt;
    ovf_inc = ovf_flag;
    if (rise) begin
      if (edge_cnt == CNT_MAX) ovf_inc = 1'b1;
      else                     cnt_inc = edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)      state_next = SETTLE;
      SETTLE:  if (timer_zero) state_next = MEASURE;
      MEASURE: if (timer_zero) state_next = DONE;
      DONE:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_comb begin
    osc_en = (state == SETTLE) || (state == MEASURE);
    busy   = (state != IDLE);
    done   = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer    <= '0;
      edge_cnt <= '0;
      ovf_flag <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) timer <= SETTLE_LOAD;
        end
        SETTLE: begin
          // Clearing here drops any edge seen in the final settle cycle.
          if (timer_zero) begin
            timer    <= GATE_LOAD;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        MEASURE: begin
          // The last gate cycle's edge is folded straight into the result.
          if (timer_zero) begin
            count    <= cnt_inc;
            overflow <= ovf_inc;
          end else begin
            timer    <= timer - 1'b1;
            edge_cnt <= cnt_inc;
            ovf_flag <= ovf_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// tb/tb_ring_osc_freq_meter.sv - randomized self-checking bench for ring_osc_freq_meter
module tb_ring_osc_freq_meter;

  localparam int S  = 8;
  localparam int G  = 100;
  localparam int SS = 2;
  localparam int HN = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        osc_in = 1'b0;
  logic        a_osc_en, a_busy, a_done, a_ovf;
  logic [15:0] a_count;
  logic        b_osc_en, b_busy, b_done, b_ovf;
  logic [3:0]  b_count;

  int n_tests = 0;
  int n_fail  = 0;
  int mode    = 0;
  int ph      = 0;
  int ec      = 0;
  bit hist [HN];

  logic [15:0] prev_a;
  logic [3:0]  prev_b;
  logic        prev_ova, prev_ovb;

  ring_osc_freq_meter #(
    .CNT_W(16), .SETTLE_CYCLES(S), .GATE_CYCLES(G), .SYNC_STAGES(SS)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .osc_in(osc_in),
    .osc_en(a_osc_en), .busy(a_busy), .done(a_done),
    .count(a_count), .overflow(a_ovf)
  );

  ring_osc_freq_meter #(
    .CNT_W(4), .SETTLE_CYCLES(S), .GATE_CYCLES(G), .SYNC_STAGES(SS)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .osc_in(osc_in),
    .osc_en(b_osc_en), .busy(b_busy), .done(b_done),
    .count(b_count), .overflow(b_ovf)
  );

  always #5 clk = ~clk;

  // Oscillator stimulus changes on the falling edge so its sampled value is unambiguous.
  always @(negedge clk) begin
    ph = ph + 1;
    case (mode)
      0:       osc_in = 1'b0;
      1:       if (ph % 2 == 0) osc_in = ~osc_in;
      2:       osc_in = ~osc_in;
      3:       osc_in = 1'($urandom_range(0, 1));
      default: if ($urandom_range(0, 7) == 0) osc_in = ~osc_in;
    endcase
  end

  // Record of osc_in as seen at every rising edge.
  always @(posedge clk) begin
    hist[ec % HN] <= osc_in;
    ec            <= ec + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Rising transitions of the sampled oscillator inside the gate window,
  // shifted by the synchronizer latency. Start sampled at edge t.
  function automatic int model_raw(input int t);
    int r = 0;
    for (int n = t + S; n < t + S + G; n++)
      if (hist[(n - SS + 1) % HN] && !hist[(n - SS) % HN]) r++;
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_osc_en"}, a_osc_en, 0);
    check_eq({tag, "_busy"}, a_busy, 0);
    check_eq({tag, "_done"}, a_done, 0);
    check_eq({tag, "_count"}, a_count, 0);
    check_eq({tag, "_ovf"}, a_ovf, 0);
    check_eq({tag, "_b_count"}, b_count, 0);
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge of
  // the first idle cycle after DONE (or right after an abort reset).
  task automatic run_meas(input int m, input bit hold, input bit noise, input int abort_k);
    int t;
    int raw;
    mode = m;
    check_eq("pre_idle", a_busy, 0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t = ec - 1;
    start = hold;
    for (int k = 1; k <= S + G + 1; k++) begin
      if (k > 1) @(negedge clk);
      if (k == abort_k) begin
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("abort");
        prev_a = '0; prev_b = '0; prev_ova = 1'b0; prev_ovb = 1'b0;
        return;
      end
      check_eq("busy", a_busy, 1);
      check_eq("osc_en", a_osc_en, (k <= S + G) ? 1 : 0);
      check_eq("done", a_done, (k == S + G + 1) ? 1 : 0);
      check_eq("b_done", b_done, (k == S + G + 1) ? 1 : 0);
      if (k <= S + G) begin
        check_eq("hold_count", a_count, prev_a);
        check_eq("hold_ovf", a_ovf, prev_ova);
        check_eq("hold_b_count", b_count, prev_b);
        start = noise ? 1'($urandom_range(0, 1)) : hold;
      end else begin
        raw      = model_raw(t);
        prev_a   = (raw > 65535) ? 16'hFFFF : 16'(raw);
        prev_ova = (raw > 65535);
        prev_b   = (raw > 15) ? 4'hF : 4'(raw);
        prev_ovb = (raw > 15);
        check_eq("count", a_count, prev_a);
        check_eq("ovf", a_ovf, prev_ova);
        check_eq("b_count", b_count, prev_b);
        check_eq("b_ovf", b_ovf, prev_ovb);
        start = hold;
      end
    end
    @(negedge clk);
    check_eq("post_busy", a_busy, 0);
    check_eq("post_done", a_done, 0);
    check_eq("post_osc_en", a_osc_en, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 3;
    prev_a = '0; prev_b = '0; prev_ova = 1'b0; prev_ovb = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_all_zero("rst");
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_all_zero("idle");
    end

    // clk/4 phase-locked square wave: 25 edges in a 100-cycle gate.
    run_meas(1, 0, 0, 0);
    check_eq("clk4_count", a_count, 25);
    check_eq("clk4_ovf", a_ovf, 0);

    // Oscillator stuck low.
    run_meas(0, 0, 0, 0);
    check_eq("zero_count", a_count, 0);

    // clk/2: 50 edges, saturates the 4-bit meter.
    run_meas(2, 0, 0, 0);
    check_eq("clk2_count", a_count, 50);
    check_eq("clk2_b_count", b_count, 15);
    check_eq("clk2_b_ovf", b_ovf, 1);

    // Held start: second measurement begins on the first idle cycle.
    run_meas(1, 1, 0, 0);
    run_meas(1, 0, 0, 0);
    check_eq("held_count", a_count, 25);

    // start pulses while busy are ignored.
    run_meas(3, 0, 1, 0);

    // Reset inside MEASURE, then a normal measurement.
    run_meas(1, 0, 0, 50);
    @(negedge clk);
    run_meas(1, 0, 0, 0);
    check_eq("after_abort_count", a_count, 25);

    for (int i = 0; i < 20; i++) begin
      run_meas($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, S + G + 1)) : 0);
      start = 1'b0;
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
